// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: RV32I/RV32M EX-stage ALU decode plus a fixed-latency multiply/divide stall sequencer.
module alu_ctrl_seq #(
  parameter int CTRL_W  = 4,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 32,
  parameter int M_EXT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              flush,
  input  logic [1:0]        alu_op,
  input  logic [2:0]        func3,
  input  logic [6:0]        func7,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              illegal,
  output logic              md_start,
  output logic [2:0]        md_op,
  output logic              stall,
  output logic              md_done
);
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND = 4'd2, OR = 4'd3, SLT = 4'd4,
                         SLTU = 4'd5, XOR = 4'd6, SLL = 4'd7, SRL = 4'd8, SRA = 4'd9;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_md_op;
  logic [3:0]    w_base, w_code;
  logic          w_legal, w_is_m, w_accept, w_run;
  always_comb begin
    case (func3)
      3'd0:    w_base = ADD;
      3'd1:    w_base = SLL;
      3'd2:    w_base = SLT;
      3'd3:    w_base = SLTU;
      3'd4:    w_base = XOR;
      3'd5:    w_base = SRL;
      3'd6:    w_base = OR;
      default: w_base = AND;
    endcase
  end
  // func7 only matters for R-type and for the immediate shift encodings
  always_comb begin
    w_code  = w_base;
    w_legal = 1'b1;
    w_is_m  = 1'b0;
    case (alu_op)
      2'b00: w_code = ADD;
      2'b01: w_code = SUB;
      2'b10:
        if (func7 == 7'h20 && (func3 == 3'd0 || func3 == 3'd5)) w_code = func3[2] ? SRA : SUB;
        else if (func7 == 7'h01 && M_EXT != 0) begin
          w_code = ADD;
          w_is_m = 1'b1;
        end
        else if (func7 != 7'h00) w_legal = 1'b0;
      default:
        if (func3 == 3'd5 && func7 == 7'h20) w_code = SRA;
        else if ((func3 == 3'd1 || func3 == 3'd5) && func7 != 7'h00) w_legal = 1'b0;
    endcase
    if (!w_legal) w_code = ADD;
  end
  assign alu_ctrl = CTRL_W'(w_code);
  assign illegal  = valid_in && !w_legal;
  assign w_accept = valid_in && w_is_m;
  assign w_run    = !rst && !flush;
  assign md_start = w_run && r_state == IDLE && w_accept;
  assign stall    = md_start || (w_run && r_state == BUSY);
  assign md_done  = w_run && r_state == DONE;
  assign md_op    = r_md_op;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_md_op <= '0;
    end else if (flush) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE:
          if (w_accept) begin
            r_state <= BUSY;
            r_md_op <= func3;
            r_cnt   <= func3[2] ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);
          end
        BUSY:
          if (r_cnt == '0) r_state <= DONE;
          else r_cnt <= r_cnt - 1'b1;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: directed checks of decode, M-op latency, flush and reset behaviour.
module tb_alu_ctrl_seq;
  logic       clk = 1'b0, rst, valid_in, flush;
  logic [1:0] alu_op;
  logic [2:0] func3;
  logic [6:0] func7;
  logic [3:0] alu_ctrl, alu_ctrl0;
  logic [2:0] md_op, md_op0;
  logic       illegal, md_start, stall, md_done, illegal0, md_start0, stall0, md_done0;
  int tests = 0, fails = 0;

  typedef struct packed {
    logic [1:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [3:0] c;
    logic       i;
  } vec_t;

  vec_t vecs [26] = '{
    '{2'd0, 3'd3, 7'h7f, 4'd0, 1'b0}, '{2'd1, 3'd7, 7'h20, 4'd1, 1'b0},
    '{2'd2, 3'd0, 7'h00, 4'd0, 1'b0}, '{2'd2, 3'd1, 7'h00, 4'd7, 1'b0},
    '{2'd2, 3'd2, 7'h00, 4'd4, 1'b0}, '{2'd2, 3'd3, 7'h00, 4'd5, 1'b0},
    '{2'd2, 3'd4, 7'h00, 4'd6, 1'b0}, '{2'd2, 3'd5, 7'h00, 4'd8, 1'b0},
    '{2'd2, 3'd6, 7'h00, 4'd3, 1'b0}, '{2'd2, 3'd7, 7'h00, 4'd2, 1'b0},
    '{2'd2, 3'd0, 7'h20, 4'd1, 1'b0}, '{2'd2, 3'd5, 7'h20, 4'd9, 1'b0},
    '{2'd2, 3'd2, 7'h20, 4'd0, 1'b1}, '{2'd2, 3'd7, 7'h7f, 4'd0, 1'b1},
    '{2'd2, 3'd0, 7'h01, 4'd0, 1'b0}, '{2'd3, 3'd0, 7'h7f, 4'd0, 1'b0},
    '{2'd3, 3'd2, 7'h20, 4'd4, 1'b0}, '{2'd3, 3'd3, 7'h00, 4'd5, 1'b0},
    '{2'd3, 3'd4, 7'h01, 4'd6, 1'b0}, '{2'd3, 3'd6, 7'h7f, 4'd3, 1'b0},
    '{2'd3, 3'd7, 7'h20, 4'd2, 1'b0}, '{2'd3, 3'd1, 7'h00, 4'd7, 1'b0},
    '{2'd3, 3'd1, 7'h20, 4'd0, 1'b1}, '{2'd3, 3'd5, 7'h00, 4'd8, 1'b0},
    '{2'd3, 3'd5, 7'h20, 4'd9, 1'b0}, '{2'd3, 3'd5, 7'h01, 4'd0, 1'b1}
  };

  always #5 clk = ~clk;

  alu_ctrl_seq dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .flush(flush), .alu_op(alu_op),
    .func3(func3), .func7(func7), .alu_ctrl(alu_ctrl), .illegal(illegal),
    .md_start(md_start), .md_op(md_op), .stall(stall), .md_done(md_done)
  );

  alu_ctrl_seq #(.M_EXT(0)) dut0 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .flush(flush), .alu_op(alu_op),
    .func3(func3), .func7(func7), .alu_ctrl(alu_ctrl0), .illegal(illegal0),
    .md_start(md_start0), .md_op(md_op0), .stall(stall0), .md_done(md_done0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic f, input logic [1:0] op, input logic [2:0] f3,
                     input logic [6:0] f7);
    valid_in = v;
    flush    = f;
    alu_op   = op;
    func3    = f3;
    func7    = f7;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    drv(1'b1, 1'b0, 2'd2, 3'd0, 7'h01);
    tick();
    tick();
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_start", {31'd0, md_start}, 32'd0);
    chk("rst_done", {31'd0, md_done}, 32'd0);
    chk("rst_md_op", {29'd0, md_op}, 32'd0);
    rst = 1'b0;
    drv(1'b0, 1'b0, 2'd0, 3'd0, 7'h00);
    tick();
    // decode sweep with flush held so M encodings cannot launch
    for (int k = 0; k < 26; k++) begin
      drv(1'b1, 1'b1, vecs[k].op, vecs[k].f3, vecs[k].f7);
      chk($sformatf("dec_ctrl_%0d", k), {28'd0, alu_ctrl}, {28'd0, vecs[k].c});
      chk($sformatf("dec_ill_%0d", k), {31'd0, illegal}, {31'd0, vecs[k].i});
      chk($sformatf("dec_start_%0d", k), {31'd0, md_start}, 32'd0);
    end
    drv(1'b0, 1'b1, 2'd2, 3'd2, 7'h20);
    chk("ill_novalid", {31'd0, illegal}, 32'd0);
    chk("ill_novalid_ctrl", {28'd0, alu_ctrl}, 32'd0);
    tick();
    drv(1'b1, 1'b0, 2'd2, 3'd0, 7'h01);
    chk("mul_c0_start", {31'd0, md_start}, 32'd1);
    chk("mul_c0_stall", {31'd0, stall}, 32'd1);
    chk("mul_c0_done", {31'd0, md_done}, 32'd0);
    tick();
    drv(1'b0, 1'b0, 2'd0, 3'd0, 7'h00);
    chk("mul_c1_stall", {31'd0, stall}, 32'd1);
    chk("mul_c1_start", {31'd0, md_start}, 32'd0);
    chk("mul_c1_md_op", {29'd0, md_op}, 32'd0);
    tick();
    chk("mul_c2_stall", {31'd0, stall}, 32'd1);
    chk("mul_c2_done", {31'd0, md_done}, 32'd0);
    tick();
    chk("mul_c3_stall", {31'd0, stall}, 32'd0);
    chk("mul_c3_done", {31'd0, md_done}, 32'd1);
    tick();
    chk("mul_c4_done", {31'd0, md_done}, 32'd0);
    chk("mul_c4_stall", {31'd0, stall}, 32'd0);
    drv(1'b1, 1'b0, 2'd2, 3'd5, 7'h01);
    chk("div_c0_start", {31'd0, md_start}, 32'd1);
    for (int c = 1; c <= 32; c++) begin
      tick();
      drv(1'b0, 1'b0, 2'd0, 3'd0, 7'h00);
      chk($sformatf("div_c%0d_stall", c), {31'd0, stall}, 32'd1);
      chk($sformatf("div_c%0d_done", c), {31'd0, md_done}, 32'd0);
    end
    tick();
    chk("div_c33_done", {31'd0, md_done}, 32'd1);
    chk("div_c33_stall", {31'd0, stall}, 32'd0);
    chk("div_c33_md_op", {29'd0, md_op}, 32'd5);
    tick();
    drv(1'b1, 1'b0, 2'd0, 3'd0, 7'h00);
    chk("add_c34_stall", {31'd0, stall}, 32'd0);
    chk("add_c34_start", {31'd0, md_start}, 32'd0);
    chk("add_c34_done", {31'd0, md_done}, 32'd0);
    tick();
    drv(1'b1, 1'b0, 2'd2, 3'd4, 7'h01);
    chk("fl_c0_start", {31'd0, md_start}, 32'd1);
    for (int c = 1; c <= 9; c++) begin
      tick();
      drv(1'b0, 1'b0, 2'd0, 3'd0, 7'h00);
      chk($sformatf("fl_c%0d_stall", c), {31'd0, stall}, 32'd1);
    end
    tick();
    drv(1'b0, 1'b1, 2'd0, 3'd0, 7'h00);
    chk("fl_c10_stall", {31'd0, stall}, 32'd0);
    chk("fl_c10_done", {31'd0, md_done}, 32'd0);
    tick();
    drv(1'b1, 1'b0, 2'd2, 3'd1, 7'h01);
    chk("fl_c11_start", {31'd0, md_start}, 32'd1);
    tick();
    drv(1'b0, 1'b0, 2'd0, 3'd0, 7'h00);
    chk("fl_c12_stall", {31'd0, stall}, 32'd1);
    chk("fl_c12_done", {31'd0, md_done}, 32'd0);
    tick();
    chk("fl_c13_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("fl_c14_done", {31'd0, md_done}, 32'd1);
    chk("fl_c14_md_op", {29'd0, md_op}, 32'd1);
    tick();
    drv(1'b1, 1'b0, 2'd2, 3'd3, 7'h01);
    chk("fd_c0_start", {31'd0, md_start}, 32'd1);
    tick();
    drv(1'b0, 1'b0, 2'd0, 3'd0, 7'h00);
    tick();
    tick();
    drv(1'b0, 1'b1, 2'd0, 3'd0, 7'h00);
    chk("fd_c3_done", {31'd0, md_done}, 32'd0);
    chk("fd_c3_stall", {31'd0, stall}, 32'd0);
    tick();
    drv(1'b0, 1'b0, 2'd0, 3'd0, 7'h00);
    chk("fd_c4_done", {31'd0, md_done}, 32'd0);
    drv(1'b1, 1'b1, 2'd2, 3'd0, 7'h01);
    chk("fi_start", {31'd0, md_start}, 32'd0);
    chk("fi_stall", {31'd0, stall}, 32'd0);
    tick();
    drv(1'b0, 1'b0, 2'd0, 3'd0, 7'h00);
    chk("fi_next_stall", {31'd0, stall}, 32'd0);
    tick();
    drv(1'b1, 1'b0, 2'd2, 3'd6, 7'h01);
    chk("rm_c0_start", {31'd0, md_start}, 32'd1);
    tick();
    drv(1'b0, 1'b0, 2'd0, 3'd0, 7'h00);
    tick();
    tick();
    rst = 1'b1;
    drv(1'b1, 1'b0, 2'd2, 3'd0, 7'h01);
    chk("rm_c3_stall", {31'd0, stall}, 32'd0);
    chk("rm_c3_start", {31'd0, md_start}, 32'd0);
    chk("rm_c3_done", {31'd0, md_done}, 32'd0);
    tick();
    chk("rm_c4_md_op", {29'd0, md_op}, 32'd0);
    chk("rm_c4_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;
    drv(1'b0, 1'b0, 2'd0, 3'd0, 7'h00);
    tick();
    chk("rm_c5_stall", {31'd0, stall}, 32'd0);
    chk("rm_c5_done", {31'd0, md_done}, 32'd0);
    chk("rm_c5_md_op", {29'd0, md_op}, 32'd0);
    for (int f = 0; f < 8; f++) begin
      tick();
      drv(1'b1, 1'b0, 2'd2, 3'(f), 7'h01);
      chk($sformatf("mx0_ill_%0d", f), {31'd0, illegal0}, 32'd1);
      chk($sformatf("mx0_stall_%0d", f), {31'd0, stall0}, 32'd0);
      chk($sformatf("mx0_start_%0d", f), {31'd0, md_start0}, 32'd0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
